// File: rtl/gpu_cmd_queue.sv
// CPU-to-rasterizer command queue: circular buffer plus a
// four-state issue sequencer with a registered request strobe.
package gpu_cmd_pkg;
  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_POINT = 2'd1,
    CMD_LINE  = 2'd2,
    CMD_FILL  = 2'd3
  } raster_command_t;

  typedef struct packed {
    raster_command_t command;
    logic [7:0]      x0;
    logic [7:0]      y0;
    logic [7:0]      x1;
    logic [7:0]      y1;
    logic [2:0]      colour;
  } cmd_entry_t;
endpackage

module gpu_cmd_queue
  import gpu_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_async,
  input  raster_command_t         cpu_command,
  input  logic [7:0]              cpu_x0,
  input  logic [7:0]              cpu_y0,
  input  logic [7:0]              cpu_x1,
  input  logic [7:0]              cpu_y1,
  input  logic [2:0]              cpu_colour,
  input  logic                    cpu_execute_request,
  output logic                    cpu_busy,
  output raster_command_t         gpu_command,
  output logic [7:0]              gpu_x0,
  output logic [7:0]              gpu_y0,
  output logic [7:0]              gpu_x1,
  output logic [7:0]              gpu_y1,
  output logic [2:0]              gpu_colour,
  output logic                    gpu_execute_request,
  input  logic                    gpu_busy,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT
  } state_t;

  state_t     state;
  state_t     state_nx;
  cmd_entry_t mem [DEPTH];
  cmd_entry_t wr_data;
  cmd_entry_t head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic       push;
  logic       pop;
  logic       has_data;

  assign cpu_busy = (level == LW'(DEPTH));
  assign push     = cpu_execute_request && !cpu_busy;
  assign has_data = (level != '0);
  assign head     = mem[rd_ptr];

  assign wr_data = '{
    command: cpu_command,
    x0:      cpu_x0,
    y0:      cpu_y0,
    x1:      cpu_x1,
    y1:      cpu_y1,
    colour:  cpu_colour
  };

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (cpu_execute_request && cpu_busy) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (has_data && !gpu_busy) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE:  state_nx = SETTLE;
      // Rasterizer only raises busy the cycle after the request.
      SETTLE: state_nx = WAIT;
      WAIT: begin
        if (!gpu_busy) begin
          if (has_data) begin
            pop      = 1'b1;
            state_nx = ISSUE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      state               <= IDLE;
      gpu_execute_request <= 1'b0;
      gpu_command         <= CMD_NOP;
      gpu_x0              <= '0;
      gpu_y0              <= '0;
      gpu_x1              <= '0;
      gpu_y1              <= '0;
      gpu_colour          <= '0;
    end else begin
      state               <= state_nx;
      gpu_execute_request <= pop;
      if (pop) begin
        gpu_command <= head.command;
        gpu_x0      <= head.x0;
        gpu_y0      <= head.y0;
        gpu_x1      <= head.x1;
        gpu_y1      <= head.y1;
        gpu_colour  <= head.colour;
      end
    end
  end

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Directed bench for gpu_cmd_queue with a small rasterizer
// busy model and an issue monitor.
module tb_gpu_cmd_queue;
  import gpu_cmd_pkg::*;

  logic            clk = 0;
  logic            rst_async = 0;
  raster_command_t cpu_command = CMD_NOP;
  logic [7:0]      cpu_x0 = 0;
  logic [7:0]      cpu_y0 = 0;
  logic [7:0]      cpu_x1 = 0;
  logic [7:0]      cpu_y1 = 0;
  logic [2:0]      cpu_colour = 0;
  logic            cpu_execute_request = 0;
  logic            cpu_busy;
  raster_command_t gpu_command;
  logic [7:0]      gpu_x0;
  logic [7:0]      gpu_y0;
  logic [7:0]      gpu_x1;
  logic [7:0]      gpu_y1;
  logic [2:0]      gpu_colour;
  logic            gpu_execute_request;
  logic            gpu_busy;
  logic [2:0]      level;
  logic            overflow;

  int checks = 0;
  int failures = 0;
  int got[$];
  int peak = 0;
  int busy_cnt = 0;
  int busy_len = 0;
  bit busy_rand = 0;
  bit hold_busy = 0;
  bit prev_req = 0;

  gpu_cmd_queue #(.DEPTH(4)) dut (
    .clk                 (clk),
    .rst_async           (rst_async),
    .cpu_command         (cpu_command),
    .cpu_x0              (cpu_x0),
    .cpu_y0              (cpu_y0),
    .cpu_x1              (cpu_x1),
    .cpu_y1              (cpu_y1),
    .cpu_colour          (cpu_colour),
    .cpu_execute_request (cpu_execute_request),
    .cpu_busy            (cpu_busy),
    .gpu_command         (gpu_command),
    .gpu_x0              (gpu_x0),
    .gpu_y0              (gpu_y0),
    .gpu_x1              (gpu_x1),
    .gpu_y1              (gpu_y1),
    .gpu_colour          (gpu_colour),
    .gpu_execute_request (gpu_execute_request),
    .gpu_busy            (gpu_busy),
    .level               (level),
    .overflow            (overflow)
  );

  always #5 clk = ~clk;

  assign gpu_busy = hold_busy || (busy_cnt > 0);

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Rasterizer model and issue monitor.
  always @(negedge clk) begin
    if (!rst_async) begin
      busy_cnt = 0;
      prev_req = 0;
    end else begin
      if (gpu_execute_request) begin
        chk("double_pulse", int'(prev_req), 0);
        chk("busy_at_req", int'(gpu_busy), 0);
        got.push_back(int'(gpu_x0));
        busy_cnt = busy_rand ? int'($urandom_range(0, 5)) : busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt = busy_cnt - 1;
      end
      prev_req = gpu_execute_request;
      if (int'(level) > peak) peak = int'(level);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input raster_command_t c, input int x0,
                       input int col);
    cpu_command = c;
    cpu_x0 = 8'(x0);
    cpu_y0 = 8'(x0 + 1);
    cpu_x1 = 8'(x0 + 2);
    cpu_y1 = 8'(x0 + 3);
    cpu_colour = 3'(col);
    cpu_execute_request = 1;
  endtask

  task automatic strobe(input raster_command_t c, input int x0,
                        input int col);
    drive(c, x0, col);
    tick();
    cpu_execute_request = 0;
  endtask

  task automatic wait_issues(input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("issue_count", got.size(), n);
  endtask

  task automatic check_order(input int base, input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("order%0d", i),
          (i < got.size()) ? got[i] : -1, base + i);
  endtask

  initial begin
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_req", int'(gpu_execute_request), 0);
    chk("rst_busy", int'(cpu_busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_colour", int'(gpu_colour), 0);
    idle(2);
    rst_async = 1;
    idle(2);

    // Single command, two-cycle latency.
    got.delete();
    busy_len = 0;
    drive(CMD_FILL, 7, 5);
    tick();
    cpu_execute_request = 0;
    chk("t1_level1", int'(level), 1);
    chk("t1_req_n1", int'(gpu_execute_request), 0);
    tick();
    chk("t1_req_n2", int'(gpu_execute_request), 1);
    chk("t1_colour", int'(gpu_colour), 5);
    chk("t1_cmd", int'(gpu_command), int'(CMD_FILL));
    chk("t1_x0", int'(gpu_x0), 7);
    chk("t1_y1", int'(gpu_y1), 10);
    chk("t1_level0", int'(level), 0);
    tick();
    chk("t1_req_n3", int'(gpu_execute_request), 0);
    chk("t1_hold", int'(gpu_colour), 5);
    idle(6);

    // Back-pressure, 20-cycle busy per request.
    got.delete();
    peak = 0;
    busy_len = 20;
    for (int i = 1; i <= 3; i++) begin
      drive(CMD_POINT, i, 1);
      tick();
    end
    cpu_execute_request = 0;
    wait_issues(3, 300);
    check_order(1, 3);
    chk("t2_peak", peak, 2);
    idle(30);

    // Full and overflow.
    got.delete();
    busy_len = 0;
    hold_busy = 1;
    for (int i = 0; i < 5; i++) begin
      drive(CMD_LINE, 10 + i, 2);
      tick();
      if (i == 3) chk("t3_full", int'(cpu_busy), 1);
    end
    cpu_execute_request = 0;
    chk("t3_level", int'(level), 4);
    chk("t3_ovf", int'(overflow), 1);
    chk("t3_no_issue", got.size(), 0);
    hold_busy = 0;
    wait_issues(4, 100);
    idle(10);
    chk("t3_exact4", got.size(), 4);
    check_order(10, 4);
    chk("t3_ovf_sticky", int'(overflow), 1);

    // Simultaneous push and pop at level 2.
    got.delete();
    hold_busy = 1;
    strobe(CMD_POINT, 20, 3);
    strobe(CMD_POINT, 21, 3);
    chk("t4_level2", int'(level), 2);
    hold_busy = 0;
    strobe(CMD_POINT, 22, 3);
    chk("t4_level_hold", int'(level), 2);
    chk("t4_req", int'(gpu_execute_request), 1);
    chk("t4_x0", int'(gpu_x0), 20);
    wait_issues(3, 100);
    check_order(20, 3);
    idle(10);

    // Wrap-around with random busy lengths.
    got.delete();
    busy_rand = 1;
    begin
      int k = 0;
      int c = 0;
      while (k < 10 && c < 500) begin
        if (!cpu_busy) begin
          drive(CMD_POINT, 30 + k, 4);
          k++;
        end else begin
          cpu_execute_request = 0;
        end
        tick();
        c++;
      end
      cpu_execute_request = 0;
      chk("t5_sent", k, 10);
    end
    wait_issues(10, 500);
    check_order(30, 10);
    busy_rand = 0;
    idle(10);
    chk("t5_level", int'(level), 0);

    // Reset while in WAIT with three queued.
    got.delete();
    busy_len = 20;
    for (int i = 0; i < 4; i++) begin
      drive(CMD_LINE, 40 + i, 6);
      tick();
    end
    cpu_execute_request = 0;
    idle(2);
    chk("t6_level3", int'(level), 3);
    rst_async = 0;
    #1;
    chk("t6_rst_level", int'(level), 0);
    chk("t6_rst_req", int'(gpu_execute_request), 0);
    chk("t6_rst_x0", int'(gpu_x0), 0);
    chk("t6_rst_cmd", int'(gpu_command), 0);
    chk("t6_rst_colour", int'(gpu_colour), 0);
    chk("t6_rst_ovf", int'(overflow), 0);
    idle(2);
    got.delete();
    rst_async = 1;
    idle(10);
    chk("t6_no_issue", got.size(), 0);
    chk("t6_level0", int'(level), 0);
    busy_len = 0;
    strobe(CMD_FILL, 50, 1);
    wait_issues(1, 20);
    check_order(50, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpu_cmd_queue.md
GPU_CMD_QUEUE -- requirements
Module: gpu_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued command entries; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  system clock, 50MHz; all state updates on rising edge.
REQ-003 SHALL have port rst_async  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 SHALL have port cpu_command  input  raster_command_t  command from CPU.
REQ-005 SHALL have ports cpu_x0, cpu_y0, cpu_x1, cpu_y1  input  8 each  CPU coordinates.
REQ-006 SHALL have port cpu_colour  input  3  CPU colour.
REQ-007 SHALL have port cpu_execute_request  input  1  one-cycle enqueue strobe from CPU.
REQ-008 SHALL have port cpu_busy  output  1  queue full; CPU must not strobe while high.
REQ-009 SHALL have port gpu_command  output  raster_command_t  command to rasterizer.
REQ-010 SHALL have ports gpu_x0, gpu_y0, gpu_x1, gpu_y1  output  8 each  coordinates to rasterizer.
REQ-011 SHALL have port gpu_colour  output  3  colour to rasterizer.
REQ-012 SHALL have port gpu_execute_request  output  1  one-cycle issue strobe to rasterizer.
REQ-013 SHALL have port gpu_busy  input  1  rasterizer busy.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  current entry count.
REQ-015 SHALL have port overflow  output  1  sticky: a strobe arrived while full.

Function
REQ-016 Entry = {command, x0, y0, x1, y1, colour}, stored in a circular buffer with write/read pointers wrapping modulo DEPTH.
REQ-017 cpu_busy SHALL be combinational: high iff level == DEPTH.
REQ-018 Strobe with level < DEPTH SHALL write the entry at the write pointer; level increments on the next edge.
REQ-019 Strobe with level == DEPTH SHALL be dropped, with no state change except overflow <= 1; overflow clears only on reset.
REQ-020 Same-cycle accepted write and pop SHALL leave level unchanged, with both pointers advancing.
REQ-021 Issue FSM states: IDLE, ISSUE, SETTLE, WAIT.
REQ-022 IDLE -> ISSUE SHALL occur when level > 0 and gpu_busy == 0; on that edge, pop the head into the gpu_* output registers.
REQ-023 ISSUE SHALL last exactly one cycle with gpu_execute_request = 1, then go to SETTLE.
REQ-024 SETTLE SHALL last one cycle, ignore gpu_busy (rasterizer raises busy the cycle after the request), then go to WAIT.
REQ-025 WAIT SHALL hold while gpu_busy == 1; when gpu_busy == 0, go to ISSUE (popping) if level > 0, else to IDLE.
REQ-026 gpu_execute_request SHALL be registered, and SHALL be high only in ISSUE, never in two consecutive cycles.
REQ-027 gpu_* data outputs SHALL hold the last issued entry until the next pop.
REQ-028 Latency: strobe in cycle N with queue empty, FSM in IDLE and gpu_busy low SHALL give gpu_execute_request high in cycle N+2 with the same data.
REQ-029 Issue order SHALL equal enqueue order; no entry is issued twice or skipped.
REQ-030 Entry written in the cycle its slot is popped SHALL be the new data, not the old data.

Reset
REQ-031 rst_async low SHALL immediately, without a clock, force FSM = IDLE, pointers = 0, level = 0, overflow = 0, gpu_execute_request = 0, and all gpu_* data outputs = 0.
REQ-032 Reset mid-operation SHALL discard all queued entries, with no strobe issued in the first cycle after release.
REQ-033 Buffer storage contents need not be reset.

Verification
REQ-034 Single command: FILL, colour 3'b101, strobed at cycle 10, gpu_busy low -> gpu_execute_request high in cycle 12 only, gpu_colour = 3'b101, level 1 -> 0.
REQ-035 Back-pressure: 3 POINT commands x0 = 1, 2, 3; gpu_busy high for 20 cycles after each request -> 3 strobes in order x0 = 1, 2, 3, each strobe after busy falls; level peaks at 2.
REQ-036 Full/overflow: DEPTH = 4, gpu_busy held high, 5 strobes -> cpu_busy high after the 4th, 5th dropped, overflow = 1, level = 4; release busy -> exactly 4 issues.
REQ-037 Simultaneous: level = 2, strobe coincides with a pop -> level stays 2, FIFO order preserved.
REQ-038 Wrap-around: 10 commands through DEPTH = 4 with random busy lengths 0..5 -> all 10 issued in order, with no request pulse longer than 1 cycle.
REQ-039 Reset mid-WAIT with level = 3: rst_async low for 2 cycles -> all outputs 0 asynchronously, and no issue occurs after release until a new strobe.
